// File: rtl/seven_seg_mux_display.sv
// -----------------------------------------------------------------------------
// seven_seg_mux_display
//
// Time-multiplexed driver for NUM_DIGITS seven-segment digits that share one
// segment bus. One digit is selected per refresh slot of REFRESH_DIV clocks.
// Each slot opens with BLANK_CYCLES clocks with every anode off, so the segment
// bus can settle without ghosting into the neighbouring digit. The shown value
// is double-buffered: loads go to a pending buffer, and that buffer is copied
// into the display buffer only when the scan wraps back to digit 0. A digit
// pattern therefore never changes part way through a frame.
//
// Ports
//   clk         in  1             system clock
//   rst_n       in  1             synchronous reset, active low
//   value       in  4*NUM_DIGITS  hex digits, digit i = value[4i+3:4i], digit 0 rightmost
//   dp_in       in  NUM_DIGITS    decimal point request per digit, 1 = lit
//   digit_en    in  NUM_DIGITS    1 = digit may light, 0 = forced blank (not buffered)
//   load        in  1             capture value/dp_in into the pending buffer
//   seg         out 7             segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
//   dp          out 1             decimal point, polarity per SEG_ACTIVE_LOW
//   an          out NUM_DIGITS    anode selects, polarity per AN_ACTIVE_LOW
//   frame_done  out 1             one-cycle pulse when the scan wraps to digit 0
// -----------------------------------------------------------------------------
module seven_seg_mux_display #(
  parameter int NUM_DIGITS     = 4,      // 1..8
  parameter int REFRESH_DIV    = 50000,  // clocks per digit slot, >= 2
  parameter int BLANK_CYCLES   = 8,      // < REFRESH_DIV
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter bit LZ_BLANK       = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  // Active-high segment pattern {g,f,e,d,c,b,a} for one hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0:    return 7'h3F;
      4'h1:    return 7'h06;
      4'h2:    return 7'h5B;
      4'h3:    return 7'h4F;
      4'h4:    return 7'h66;
      4'h5:    return 7'h6D;
      4'h6:    return 7'h7D;
      4'h7:    return 7'h07;
      4'h8:    return 7'h7F;
      4'h9:    return 7'h6F;
      4'hA:    return 7'h77;
      4'hB:    return 7'h7C;
      4'hC:    return 7'h39;
      4'hD:    return 7'h5E;
      4'hE:    return 7'h79;
      default: return 7'h71;
    endcase
  endfunction

  // Scan position
  logic [CNT_W-1:0] r_div_cnt;
  logic [IDX_W-1:0] r_idx;

  // Double buffer: pending collects loads, display feeds the decoder
  logic [4*NUM_DIGITS-1:0] r_pend_val;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic [4*NUM_DIGITS-1:0] r_disp_val;
  logic [NUM_DIGITS-1:0]   r_disp_dp;

  // Registered pin drivers
  logic [6:0]            r_seg;
  logic                  r_dp;
  logic [NUM_DIGITS-1:0] r_an;
  logic                  r_frame_done;

  logic                  w_slot_wrap;
  logic                  w_frame_wrap;
  logic [3:0]            w_nibble;
  logic                  w_dp_req;
  logic                  w_en;
  logic [NUM_DIGITS-1:0] w_an_onehot;
  logic                  w_upper_zero;
  logic                  w_blank;
  logic [6:0]            w_seg_hi;
  logic                  w_dp_hi;
  logic [NUM_DIGITS-1:0] w_an_hi;

  assign w_slot_wrap  = (r_div_cnt == CNT_LAST);
  assign w_frame_wrap = w_slot_wrap && (r_idx == IDX_LAST);

  // Select the current digit's nibble/dp/enable and find out whether every
  // digit from the current one up to the most significant is zero.
  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_nibble     = 4'h0;
    w_dp_req     = 1'b0;
    w_en         = 1'b0;
    w_an_onehot  = '0;
    w_upper_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IDX_W'(i) == r_idx) begin
        w_nibble       = r_disp_val[4*i +: 4];
        w_dp_req       = r_disp_dp[i];
        w_en           = digit_en[i];
        w_an_onehot[i] = 1'b1;
      end
      if ((IDX_W'(i) >= r_idx) && (r_disp_val[4*i +: 4] != 4'h0)) begin
        w_upper_zero = 1'b0;
      end
    end
  end

  // Digit 0 is never suppressed, so an all-zero value still shows "0".
  assign w_blank = !w_en
                || (r_div_cnt < CNT_BLANK)
                || (LZ_BLANK && (r_idx != '0) && w_upper_zero);

  // Lit levels in active-high form; polarity is applied once at the register.
  assign w_seg_hi = w_blank ? 7'h00 : hex_to_seg(w_nibble);
  assign w_dp_hi  = w_blank ? 1'b0  : w_dp_req;
  assign w_an_hi  = w_blank ? '0    : w_an_onehot;

  // Slot counter and digit index. frame_done is registered alongside idx so
  // it is high exactly in the cycle idx returns to 0.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div_cnt    <= '0;
      r_idx        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_frame_wrap;
      if (w_slot_wrap) begin
        r_div_cnt <= '0;
        r_idx     <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
      end
    end
  end

  // Buffers. A load arriving on the wrap cycle bypasses pending so it shows
  // in the frame that is just starting.
  // NOTE: both buffers are reset so the first frame after power-up shows a
  // defined "0" instead of whatever the flops woke up with.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pend_val <= '0;
      r_pend_dp  <= '0;
      r_disp_val <= '0;
      r_disp_dp  <= '0;
    end else begin
      if (load) begin
        r_pend_val <= value;
        r_pend_dp  <= dp_in;
      end
      if (w_frame_wrap) begin
        r_disp_val <= load ? value : r_pend_val;
        r_disp_dp  <= load ? dp_in : r_pend_dp;
      end
    end
  end

  // Output registers: one clock behind the div_cnt/idx that selected them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_seg <= {7{SEG_ACTIVE_LOW}};
      r_dp  <= SEG_ACTIVE_LOW;
      r_an  <= {NUM_DIGITS{AN_ACTIVE_LOW}};
    end else begin
      r_seg <= w_seg_hi ^ {7{SEG_ACTIVE_LOW}};
      r_dp  <= w_dp_hi ^ SEG_ACTIVE_LOW;
      r_an  <= w_an_hi ^ {NUM_DIGITS{AN_ACTIVE_LOW}};
    end
  end

  assign seg        = r_seg;
  assign dp         = r_dp;
  assign an         = r_an;
  assign frame_done = r_frame_done;

endmodule
